encoder_turn_tracker: RTL and testbench
=======================================

// Module: encoder_turn_tracker
// PURPOSE
//  Consumes 19-bit single-turn absolute angle words + data_valid strobe from the SPI encoder reader.
//  Same clock domain as the reader.
//  Extends the angle to a multi-turn signed position by detecting wrap-around.
//  Produces a per-sample signed velocity (delta), rejects implausible jumps (glitches),
//  and flags a fault after repeated rejects. Output feeds the motion/control logic.
// PARAMETERS
//  ENC_W     19    single-turn angle width (counts/rev = 2^ENC_W)
//  TURN_W    13    signed turn-counter width; pos width = TURN_W+ENC_W
//  MAX_STEP  4096  max accepted |delta| per sample; must be <= 2^(ENC_W-1)-1
//  MAX_REJ   3     consecutive rejects that trigger FAULT (>=1)
// PORTS
//  sck        in   1              clock (same as encoder reader)
//  rst_n      in   1              synchronous active-low reset
//  enc_val    in   ENC_W          single-turn angle, qualified by enc_valid
//  enc_valid  in   1              one-cycle strobe, new angle sample
//  zero_req   in   1              one-cycle strobe: clear turns/fault, re-acquire
//  pos        out  TURN_W+ENC_W   signed multi-turn position {turns, angle}
//  vel        out  ENC_W          signed counts per accepted sample
//  pos_valid  out  1              one-cycle strobe, pos/vel updated
//  locked     out  1              1 while in TRACK
//  glitch     out  1              one-cycle strobe, sample rejected
//  fault      out  1              sticky until zero_req or reset
// BEHAVIOUR
//  Reset: state=IDLE; pos, vel, pos_valid, locked, glitch, fault, turns, prev, rej_cnt all 0.
//  All outputs registered; pos_valid/glitch assert 1 cycle after the enc_valid cycle.
//  delta = (enc_val - prev) mod 2^ENC_W, interpreted as signed ENC_W bits.
//  IDLE: on enc_valid -> prev=enc_val, turns=0, pos={0,enc_val}, vel=0, pos_valid=1, locked=1, ->TRACK.
//  TRACK, |delta|<=MAX_STEP (accept):
//    - enc_val<prev && delta>0 -> turns+1; enc_val>prev && delta<0 -> turns-1.
//    - turns wraps modulo 2^TURN_W (no saturation).
//    - prev=enc_val; pos={turns_new,enc_val}; vel=delta; pos_valid=1; rej_cnt=0.
//  TRACK, |delta|>MAX_STEP (reject):
//    - glitch=1; prev/turns/pos/vel unchanged; no pos_valid; rej_cnt+1.
//    - if rej_cnt reaches MAX_REJ -> FAULT, fault=1, locked=0.
//  delta=0: accepted, vel=0, pos_valid=1.
//  FAULT: enc_valid ignored (no pos_valid/glitch); only zero_req or reset leave.
//  zero_req (any state):
//    - next state IDLE; turns=0, rej_cnt=0, fault=0, locked=0.
//    - pos/vel hold last value; wins over simultaneous enc_valid (that sample dropped).
//  Reset mid-operation: immediate return to reset values; next sample is an IDLE acquisition.
//  enc_valid while previous result strobing: each strobe processed independently (1 sample/cycle).
// CONFIGURATION
//  VEL_AVG_EN defined:
//    - vel = (sum of last 4 accepted deltas incl. current) >>> 2, arithmetic shift.
//    - 4-entry delta history cleared on IDLE entry; IDLE acquisition adds no entry.
//    - Latency unchanged.
//  VEL_AVG_EN undefined: vel = raw delta; no history registers.
// TESTING
//  1 reset; enc_val=100 strobe -> next cycle pos_valid=1, pos=100, vel=0, locked=1
//  2 fwd wrap: accepted 524200, then 50 -> delta=138, pos=524338 (turns=1), vel=138
//  3 rev wrap: from pos=524338 send 524280 -> delta=-58, pos=524280 (turns=0), vel=-58
//  4 prev=1000, three samples 200000 -> glitch x3, no pos_valid, then fault=1, locked=0;
//    further samples ignored; zero_req -> fault=0; next sample 7 -> pos=7, vel=0
//  5 zero_req same cycle as enc_valid=500 in TRACK -> sample dropped, no pos_valid;
//    next enc_valid=600 -> pos=600, vel=0
//  6 VEL_AVG_EN: acquire 0, then deltas +4,+8,+12,+16 -> vel 1,3,6,10; without macro -> vel 4,8,12,16

Source files
------------

// File: rtl/encoder_turn_tracker_if.sv
// Encoder turn tracker bundle: angle samples in, multi-turn
// position/velocity and status out.
interface encoder_turn_tracker_if #(
    parameter int ENC_W  = 19,
    parameter int TURN_W = 13
);
    logic [ENC_W-1:0]        enc_val;
    logic                    enc_valid;
    logic                    zero_req;
    logic [TURN_W+ENC_W-1:0] pos;
    logic [ENC_W-1:0]        vel;
    logic                    pos_valid;
    logic                    locked;
    logic                    glitch;
    logic                    fault;

    modport master (
        output enc_val, enc_valid, zero_req,
        input  pos, vel, pos_valid, locked, glitch, fault
    );

    modport slave (
        input  enc_val, enc_valid, zero_req,
        output pos, vel, pos_valid, locked, glitch, fault
    );
endinterface

// File: rtl/encoder_turn_tracker.sv
// Multi-turn extension of a single-turn absolute encoder with glitch
// rejection and fault latch. Optional VEL_AVG_EN: 4-sample velocity average.
module encoder_turn_tracker #(
    parameter int ENC_W    = 19,
    parameter int TURN_W   = 13,
    parameter int MAX_STEP = 4096,
    parameter int MAX_REJ  = 3
) (
    input  logic                 sck,
    input  logic                 rst_n,
    encoder_turn_tracker_if.slave bus
);
    localparam int POS_W = TURN_W + ENC_W;
    localparam int REJ_W = $clog2(MAX_REJ + 1);
    localparam logic [ENC_W-1:0] STEP_LIM = ENC_W'(MAX_STEP);
    localparam logic [REJ_W-1:0] REJ_LIM  = REJ_W'(MAX_REJ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_FAULT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ENC_W-1:0]    r_prev, w_prev_nxt;
    logic [TURN_W-1:0]   r_turns, w_turns_nxt;
    logic [POS_W-1:0]    r_pos, w_pos_nxt;
    logic [ENC_W-1:0]    r_vel, w_vel_nxt;
    logic [REJ_W-1:0]    r_rej, w_rej_nxt;
    logic                r_pos_valid, w_pos_valid_nxt;
    logic                r_locked, w_locked_nxt;
    logic                r_glitch, w_glitch_nxt;
    logic                r_fault, w_fault_nxt;

    logic [ENC_W-1:0]    w_delta;
    logic [ENC_W-1:0]    w_abs;
    logic [ENC_W-1:0]    w_vel_acc;
    logic                w_accept;
    logic                w_fwd;
    logic                w_rev;

    // Shortest signed distance from previous angle, and wrap direction.
    assign w_delta  = bus.enc_val - r_prev;
    assign w_abs    = w_delta[ENC_W-1] ? -w_delta : w_delta;
    assign w_accept = (w_abs <= STEP_LIM);
    assign w_fwd    = (bus.enc_val < r_prev) && !w_delta[ENC_W-1];
    assign w_rev    = (bus.enc_val > r_prev) && w_delta[ENC_W-1];

`ifdef VEL_AVG_EN
    logic [ENC_W-1:0]        r_hist0, r_hist1, r_hist2;
    logic signed [ENC_W+1:0] w_sum;

    assign w_sum = {{2{w_delta[ENC_W-1]}}, w_delta}
                 + {{2{r_hist0[ENC_W-1]}}, r_hist0}
                 + {{2{r_hist1[ENC_W-1]}}, r_hist1}
                 + {{2{r_hist2[ENC_W-1]}}, r_hist2};
    assign w_vel_acc = ENC_W'(w_sum >>> 2);

    // Delta history: empty on every (re)acquisition, shifts on accept.
    always_ff @(posedge sck) begin
        if (!rst_n || bus.zero_req || r_state == S_IDLE) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
        end else if (r_state == S_TRACK && bus.enc_valid && w_accept) begin
            r_hist2 <= r_hist1;
            r_hist1 <= r_hist0;
            r_hist0 <= w_delta;
        end
    end
`else
    assign w_vel_acc = w_delta;
`endif

    // State register.
    always_ff @(posedge sck) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and next registered outputs; zero_req beats enc_valid.
    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_turns_nxt     = r_turns;
        w_pos_nxt       = r_pos;
        w_vel_nxt       = r_vel;
        w_rej_nxt       = r_rej;
        w_pos_valid_nxt = 1'b0;
        w_glitch_nxt    = 1'b0;
        w_locked_nxt    = r_locked;
        w_fault_nxt     = r_fault;
        if (bus.zero_req) begin
            w_state_nxt  = S_IDLE;
            w_turns_nxt  = '0;
            w_rej_nxt    = '0;
            w_fault_nxt  = 1'b0;
            w_locked_nxt = 1'b0;
        end else if (bus.enc_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    w_prev_nxt      = bus.enc_val;
                    w_turns_nxt     = '0;
                    w_rej_nxt       = '0;
                    w_pos_nxt       = {{TURN_W{1'b0}}, bus.enc_val};
                    w_vel_nxt       = '0;
                    w_pos_valid_nxt = 1'b1;
                    w_locked_nxt    = 1'b1;
                    w_state_nxt     = S_TRACK;
                end
                S_TRACK: begin
                    if (w_accept) begin
                        if (w_fwd)      w_turns_nxt = r_turns + TURN_W'(1);
                        else if (w_rev) w_turns_nxt = r_turns - TURN_W'(1);
                        w_prev_nxt      = bus.enc_val;
                        w_pos_nxt       = {w_turns_nxt, bus.enc_val};
                        w_vel_nxt       = w_vel_acc;
                        w_pos_valid_nxt = 1'b1;
                        w_rej_nxt       = '0;
                    end else begin
                        w_glitch_nxt = 1'b1;
                        w_rej_nxt    = r_rej + REJ_W'(1);
                        if (w_rej_nxt == REJ_LIM) begin
                            w_state_nxt  = S_FAULT;
                            w_fault_nxt  = 1'b1;
                            w_locked_nxt = 1'b0;
                        end
                    end
                end
                S_FAULT: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge sck) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_turns     <= '0;
            r_pos       <= '0;
            r_vel       <= '0;
            r_rej       <= '0;
            r_pos_valid <= 1'b0;
            r_glitch    <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_prev      <= w_prev_nxt;
            r_turns     <= w_turns_nxt;
            r_pos       <= w_pos_nxt;
            r_vel       <= w_vel_nxt;
            r_rej       <= w_rej_nxt;
            r_pos_valid <= w_pos_valid_nxt;
            r_glitch    <= w_glitch_nxt;
            r_locked    <= w_locked_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign bus.pos       = r_pos;
    assign bus.vel       = r_vel;
    assign bus.pos_valid = r_pos_valid;
    assign bus.glitch    = r_glitch;
    assign bus.locked    = r_locked;
    assign bus.fault     = r_fault;
endmodule

// File: tb/tb_encoder_turn_tracker.sv
// Scoreboard bench for encoder_turn_tracker; expectations are queued as
// each sample is driven and popped when its result cycle is sampled.
module tb_encoder_turn_tracker;
    localparam int K_ACQ  = 0;
    localparam int K_ACC  = 1;
    localparam int K_GLI  = 2;
    localparam int K_IGN  = 3;
    localparam int K_ZERO = 4;
    localparam int K_COLL = 5;

    typedef struct packed {
        logic        pv;
        logic        gl;
        logic        lk;
        logic        ft;
        logic [31:0] pos;
        logic [18:0] vel;
    } exp_t;

    logic sck = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t        sb[$];
    logic [31:0] m_pos;
    logic [18:0] m_vel;
    logic        m_lk, m_ft;
    int          m_rej;
    int          mh[3];

    encoder_turn_tracker_if #(.ENC_W(19), .TURN_W(13)) bus ();

    encoder_turn_tracker #(
        .ENC_W(19), .TURN_W(13), .MAX_STEP(4096), .MAX_REJ(3)
    ) dut (
        .sck   (sck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sck = ~sck;

    task automatic model_reset();
        m_pos = '0; m_vel = '0; m_lk = 1'b0; m_ft = 1'b0; m_rej = 0;
        mh = '{0, 0, 0};
    endtask

    // Queue the expected result of one sample, then drive it for one cycle.
    task automatic stim(input int k, input int val, input int p, input int d);
        exp_t e;
        int   s;
        int   v;
        case (k)
            K_ACQ: begin
                mh = '{0, 0, 0};
                m_pos = {13'd0, val[18:0]}; m_vel = '0;
                m_lk = 1'b1; m_ft = 1'b0; m_rej = 0;
                e = '{1'b1, 1'b0, m_lk, m_ft, m_pos, m_vel};
            end
            K_ACC: begin
`ifdef VEL_AVG_EN
                s = d + mh[0] + mh[1] + mh[2];
                mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = d;
                v = s >>> 2;
`else
                s = d;
                v = s;
`endif
                m_vel = v[18:0]; m_pos = p; m_rej = 0;
                e = '{1'b1, 1'b0, m_lk, m_ft, m_pos, m_vel};
            end
            K_GLI: begin
                m_rej++;
                if (m_rej == 3) begin m_ft = 1'b1; m_lk = 1'b0; end
                e = '{1'b0, 1'b1, m_lk, m_ft, m_pos, m_vel};
            end
            K_ZERO, K_COLL: begin
                m_lk = 1'b0; m_ft = 1'b0; m_rej = 0;
                e = '{1'b0, 1'b0, m_lk, m_ft, m_pos, m_vel};
            end
            default: e = '{1'b0, 1'b0, m_lk, m_ft, m_pos, m_vel};
        endcase
        sb.push_back(e);
        bus.enc_valid = (k != K_ZERO);
        bus.zero_req  = (k == K_ZERO) || (k == K_COLL);
        bus.enc_val   = val[18:0];
        @(negedge sck);
        bus.enc_valid = 1'b0;
        bus.zero_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enc_valid = 1'b1; bus.enc_val = 19'd55; bus.zero_req = 1'b0;
        repeat (3) @(negedge sck);
        bus.enc_valid = 1'b0;
        checks++;
        if ({bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel} !== 55'd0) begin
            failures++;
            $display("FAIL reset got pv=%0b gl=%0b lk=%0b ft=%0b pos=%0h vel=%0h exp all 0",
                     bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel);
        end
        model_reset();
        rst_n = 1'b1;
        @(negedge sck);
    endtask

    task automatic run_table(input string name, input int n,
                             input int k[12], input int val[12],
                             input int p[12], input int d[12]);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            stim(k[i], val[i], p[i], d[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel} !== e) begin
                failures++;
                $display("FAIL %s[%0d] got pv=%0b gl=%0b lk=%0b ft=%0b pos=%0h vel=%0h exp pv=%0b gl=%0b lk=%0b ft=%0b pos=%0h vel=%0h",
                         name, i, bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel,
                         e.pv, e.gl, e.lk, e.ft, e.pos, e.vel);
            end
        end
    endtask

    task automatic test_acquire();
        run_table("acquire", 1, '{K_ACQ, 0,0,0,0,0,0,0,0,0,0,0},
                  '{100, 0,0,0,0,0,0,0,0,0,0,0}, '{100, 0,0,0,0,0,0,0,0,0,0,0},
                  '{0, 0,0,0,0,0,0,0,0,0,0,0});
    endtask

    task automatic test_fwd_wrap();
        run_table("fwd_wrap", 3, '{K_ZERO, K_ACQ, K_ACC, 0,0,0,0,0,0,0,0,0},
                  '{0, 524200, 50, 0,0,0,0,0,0,0,0,0},
                  '{0, 524200, 524338, 0,0,0,0,0,0,0,0,0},
                  '{0, 0, 138, 0,0,0,0,0,0,0,0,0});
    endtask

    task automatic test_rev_wrap();
        run_table("rev_wrap", 1, '{K_ACC, 0,0,0,0,0,0,0,0,0,0,0},
                  '{524280, 0,0,0,0,0,0,0,0,0,0,0},
                  '{524280, 0,0,0,0,0,0,0,0,0,0,0},
                  '{-58, 0,0,0,0,0,0,0,0,0,0,0});
    endtask

    task automatic test_turn_wrap();
        run_table("turn_wrap", 4, '{K_ZERO, K_ACQ, K_ACC, K_ACC, 0,0,0,0,0,0,0,0},
                  '{0, 10, 524280, 5, 0,0,0,0,0,0,0,0},
                  '{0, 10, -8, 5, 0,0,0,0,0,0,0,0},
                  '{0, 0, -18, 13, 0,0,0,0,0,0,0,0});
    endtask

    task automatic test_back_to_back();
        run_table("b2b_step", 9,
                  '{K_ACC, K_GLI, K_ACC, K_GLI, K_GLI, K_ACC, K_GLI, K_GLI, K_ACC, 0,0,0},
                  '{4101, 8198, 5, 200000, 200000, 6, 200000, 200000, 7, 0,0,0},
                  '{4101, 0, 5, 0, 0, 6, 0, 0, 7, 0,0,0},
                  '{4096, 0, -4096, 0, 0, 1, 0, 0, 1, 0,0,0});
    endtask

    task automatic test_glitch_fault();
        run_table("fault", 9,
                  '{K_ZERO, K_ACQ, K_GLI, K_GLI, K_GLI, K_IGN, K_IGN, K_ZERO, K_ACQ, 0,0,0},
                  '{0, 1000, 200000, 200000, 200000, 300, 1000, 0, 7, 0,0,0},
                  '{0, 1000, 0, 0, 0, 0, 0, 0, 7, 0,0,0},
                  '{0,0,0,0,0,0,0,0,0, 0,0,0});
    endtask

    task automatic test_zero_collision();
        run_table("zero_coll", 2, '{K_COLL, K_ACQ, 0,0,0,0,0,0,0,0,0,0},
                  '{500, 600, 0,0,0,0,0,0,0,0,0,0},
                  '{0, 600, 0,0,0,0,0,0,0,0,0,0},
                  '{0,0,0,0,0,0,0,0,0,0,0,0});
    endtask

    task automatic test_vel();
`ifdef VEL_AVG_EN
        int vx[6] = '{0, 0, 1, 3, 6, 10};
`else
        int vx[6] = '{0, 0, 4, 8, 12, 16};
`endif
        int          k[6]  = '{K_ZERO, K_ACQ, K_ACC, K_ACC, K_ACC, K_ACC};
        int          vl[6] = '{0, 0, 4, 12, 24, 40};
        int          dl[6] = '{0, 0, 4, 8, 12, 16};
        logic [18:0] want;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            stim(k[i], vl[i], vl[i], dl[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel} !== e) begin
                failures++;
                $display("FAIL vel_sb[%0d] got pv=%0b pos=%0h vel=%0h exp pv=%0b pos=%0h vel=%0h",
                         i, bus.pos_valid, bus.pos, bus.vel, e.pv, e.pos, e.vel);
            end
            if (i >= 2) begin
                want = vx[i][18:0];
                checks++;
                if (bus.vel !== want) begin
                    failures++;
                    $display("FAIL vel_const[%0d] got vel=%0d exp vel=%0d", i, bus.vel, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        bus.enc_valid = 1'b1; bus.enc_val = 19'd9000;
        @(negedge sck);
        bus.enc_valid = 1'b0;
        checks++;
        if ({bus.pos_valid, bus.glitch, bus.locked, bus.fault, bus.pos, bus.vel} !== 55'd0) begin
            failures++;
            $display("FAIL reset_mid got pv=%0b lk=%0b ft=%0b pos=%0h vel=%0h exp all 0",
                     bus.pos_valid, bus.locked, bus.fault, bus.pos, bus.vel);
        end
        model_reset();
        rst_n = 1'b1;
        run_table("reset_reacq", 2, '{K_ACQ, K_ACC, 0,0,0,0,0,0,0,0,0,0},
                  '{300, 310, 0,0,0,0,0,0,0,0,0,0},
                  '{300, 310, 0,0,0,0,0,0,0,0,0,0},
                  '{0, 10, 0,0,0,0,0,0,0,0,0,0});
    endtask

    initial begin
        bus.enc_valid = 1'b0;
        bus.enc_val   = '0;
        bus.zero_req  = 1'b0;
        model_reset();
        @(negedge sck);
        test_reset();
        test_acquire();
        test_fwd_wrap();
        test_rev_wrap();
        test_turn_wrap();
        test_back_to_back();
        test_glitch_fault();
        test_zero_collision();
        test_vel();
        test_reset_mid();
        repeat (2) @(negedge sck);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
